// File: rtl/branch_target_predictor.sv
// ============================================================================
// Module   : branch_target_predictor
// Purpose  : Direct-mapped BTB with 2-bit counters. It predicts the next fetch
//            PC and raises a registered redirect when ID resolves a mispredict.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_next_pc,
  input  logic             if_stall,
  input  logic             if_flush,
  input  logic             upd_valid,
  input  logic             upd_is_branch,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [1:0] c_CTR_SNT = 2'b00;
  localparam logic [1:0] c_CTR_WNT = 2'b01;
  localparam logic [1:0] c_CTR_WT  = 2'b10;
  localparam logic [1:0] c_CTR_ST  = 2'b11;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic             id_pred_taken_q;
  logic [31:0]      id_pred_target_q;
  logic             mispredict_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic             w_br_taken;
  logic             w_mis;
  logic             w_btb_we;
  logic [31:0]      w_actual_next;
  logic [1:0]       ctr_d;
  logic [31:0]      target_d;
  logic             w_unused_pc_bits;

  // Fetch-side lookup reads pre-update contents, so a same-cycle write is
  // only visible from the following cycle.
  assign w_idx        = if_pc[IDX_W+1:2];
  assign w_tag        = if_pc[31:IDX_W+2];
  assign w_hit        = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign pred_taken   = w_hit & ctr_q[w_idx][1];
  assign pred_next_pc = pred_taken ? target_q[w_idx] : (if_pc + 32'd4);

  assign w_u_idx       = upd_pc[IDX_W+1:2];
  assign w_u_tag       = upd_pc[31:IDX_W+2];
  assign w_u_hit       = valid_q[w_u_idx] && (tag_q[w_u_idx] == w_u_tag);
  assign w_br_taken    = upd_is_branch & upd_taken;
  assign w_actual_next = w_br_taken ? upd_target : (upd_pc + 32'd4);
  assign w_mis         = (id_pred_taken_q != w_br_taken) |
                         (id_pred_taken_q & w_br_taken & (id_pred_target_q != upd_target));
  assign w_btb_we      = upd_valid & upd_is_branch;

  assign w_unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  always_comb begin
    ctr_d    = ctr_q[w_u_idx];
    target_d = target_q[w_u_idx];
    if (!w_u_hit) begin
      ctr_d    = upd_taken ? c_CTR_WT : c_CTR_WNT;
      target_d = upd_target;
    end else if (upd_taken) begin
      ctr_d    = (ctr_q[w_u_idx] == c_CTR_ST) ? c_CTR_ST : ctr_q[w_u_idx] + 2'd1;
      target_d = upd_target;
    end else begin
      ctr_d    = (ctr_q[w_u_idx] == c_CTR_SNT) ? c_CTR_SNT : ctr_q[w_u_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= c_CTR_WNT;
      end
    end else if (w_btb_we) begin
      valid_q[w_u_idx]  <= 1'b1;
      tag_q[w_u_idx]    <= w_u_tag;
      target_q[w_u_idx] <= target_d;
      ctr_q[w_u_idx]    <= ctr_d;
    end
  end

  // A flush only drops the taken bit; the stale target is harmless then.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_pred_taken_q  <= 1'b0;
      id_pred_target_q <= '0;
    end else if (if_flush) begin
      id_pred_taken_q  <= 1'b0;
    end else if (!if_stall) begin
      id_pred_taken_q  <= pred_taken;
      id_pred_target_q <= target_q[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q <= upd_valid & w_mis;
      if (upd_valid) begin
        redirect_pc_q <= w_actual_next;
      end
      if (w_btb_we) begin
        branch_cnt_q <= branch_cnt_q + 1'b1;
      end
      if (upd_valid && w_mis) begin
        mispred_cnt_q <= mispred_cnt_q + 1'b1;
      end
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

`default_nettype wire
